// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// ILLEGAL_TRAP_EN adds the TRAP state for unrecognised opcodes.
package ctrl_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned SEL_W = 2;

    localparam logic [OP_W-1:0] OP_LW = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I  = 7'b0010011;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES  = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    typedef struct packed {
        logic             mem_req;
        logic             mem_write;
        logic             adr_src;
        logic             ir_write;
        logic             pc_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             imm_src;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_dec.sv
// Combinational decode of FSM state (plus Op and MemReady) into datapath controls.
module ctrl_out_dec
    import ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            mem_ready_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALURES;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.imm_src   = (op_i == OP_SW);
            end
            S_MEMREAD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_MEMDATA;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.adr_src   = 1'b1;
                ctrl_o.imm_src   = 1'b1;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
                ctrl_o.imm_src   = 1'b0;
            end
            S_ALUWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register, sequencing, retire counter and reset gating.
// ILLEGAL_TRAP_EN parks unrecognised opcodes in TRAP and raises Illegal.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Op,
    input  logic               MemReady,
    output logic               MemReq,
    output logic               MemWrite,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ALUOp,
    output logic               ImmSrc,
    output logic [CNT_W-1:0]   InstrCount,
    output logic               Illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    ctrl_t            ctrl_raw, ctrl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = state_q;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    ctrl_out_dec u_dec (
        .state_i     (state_q),
        .op_i        (Op),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl_raw)
    );

    // FETCH decodes to MemReq=1, so controls must be masked while reset is held.
    assign ctrl = rst ? ctrl_raw : '0;

    assign MemReq     = ctrl.mem_req;
    assign MemWrite   = ctrl.mem_write;
    assign AdrSrc     = ctrl.adr_src;
    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign RegWrite   = ctrl.reg_write;
    assign ResultSrc  = ctrl.result_src;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign ImmSrc     = ctrl.imm_src;
    assign InstrCount = cnt_q;

`ifdef ILLEGAL_TRAP_EN
    assign Illegal = rst && (state_q == S_TRAP);
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus a randomized
// instruction stream checked against per-instruction cycle/strobe accounting.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc}
    localparam logic [14:0] V_FETCH_RDY  = 15'b100110_10_00_10_00_0;
    localparam logic [14:0] V_FETCH_WAIT = 15'b100000_10_00_10_00_0;
    localparam logic [14:0] V_DECODE     = 15'b000000_00_01_01_00_0;
    localparam logic [14:0] V_MEMADR_LW  = 15'b000000_00_10_01_00_0;
    localparam logic [14:0] V_MEMADR_SW  = 15'b000000_00_10_01_00_1;
    localparam logic [14:0] V_MEMREAD    = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] V_MEMWB      = 15'b000001_01_00_00_00_0;
    localparam logic [14:0] V_MEMWRITE   = 15'b111000_00_00_00_00_1;
    localparam logic [14:0] V_EXECR      = 15'b000000_00_10_00_10_0;
    localparam logic [14:0] V_EXECI      = 15'b000000_00_10_01_10_0;
    localparam logic [14:0] V_ALUWB      = 15'b000001_00_00_00_00_0;

    logic        clk, rst, MemReady;
    logic [6:0]  Op;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [31:0] InstrCount;

    logic        w_rst, w_mr;
    logic [6:0]  w_op;
    logic        w_req, w_wr, w_as, w_ir, w_pc, w_rw, w_imm, w_ill;
    logic [1:0]  w_rs, w_sa, w_sb, w_aop;
    logic [1:0]  w_cnt;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt = '0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .InstrCount(InstrCount),
        .Illegal(Illegal)
    );

    // Narrow counter instance so wrap-around is reachable in a few cycles.
    multicycle_ctrl #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(w_rst), .Op(w_op), .MemReady(w_mr),
        .MemReq(w_req), .MemWrite(w_wr), .AdrSrc(w_as), .IRWrite(w_ir),
        .PCWrite(w_pc), .RegWrite(w_rw), .ResultSrc(w_rs), .ALUSrcA(w_sa),
        .ALUSrcB(w_sb), .ALUOp(w_aop), .ImmSrc(w_imm), .InstrCount(w_cnt),
        .Illegal(w_ill)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pack_outs();
        return {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
    endfunction

    task automatic test_reset();
        rst = 1'b0; MemReady = 1'b1; Op = OP_LW;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (pack_outs() !== 15'd0 || InstrCount !== 32'd0 || Illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold outs=%b cnt=%0d ill=%b want outs=0 cnt=0 ill=0", pack_outs(), InstrCount, Illegal);
        end
        total++;
        if (w_cnt !== 2'd0 || w_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_w cnt=%0d req=%b want 0 0", w_cnt, w_req);
        end
        @(negedge clk);
        rst = 1'b1; MemReady = 1'b0;
        #1;
        total++;
        if (pack_outs() !== V_FETCH_WAIT || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL reset_release outs=%b cnt=%0d want outs=%b cnt=0", pack_outs(), InstrCount, V_FETCH_WAIT);
        end
        exp_cnt = '0;
    endtask

    task automatic test_lw_zero_wait();
        logic [14:0] ev [6];
        logic [5:0]  mr;
        ev = '{V_FETCH_RDY, V_DECODE, V_MEMADR_LW, V_MEMREAD, V_MEMWB, V_FETCH_WAIT};
        mr = 6'b011111;
        Op = OP_LW;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            MemReady = mr[c];
            #1;
            total++;
            if (pack_outs() !== ev[c] || InstrCount !== ((c == 5) ? exp_cnt + 32'd1 : exp_cnt)) begin
                bad++;
                $display("FAIL lw_cyc%0d outs=%b cnt=%0d want outs=%b", c + 1, pack_outs(), InstrCount, ev[c]);
            end
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_sw_wait();
        logic [14:0] ev [8];
        logic [7:0]  mr;
        ev = '{V_FETCH_RDY, V_DECODE, V_MEMADR_SW, V_MEMWRITE, V_MEMWRITE, V_MEMWRITE,
               V_MEMWRITE, V_FETCH_WAIT};
        mr = 8'b01000111;
        Op = OP_SW;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            MemReady = mr[c];
            #1;
            total++;
            if (pack_outs() !== ev[c] || InstrCount !== ((c == 7) ? exp_cnt + 32'd1 : exp_cnt)) begin
                bad++;
                $display("FAIL sw_cyc%0d outs=%b cnt=%0d want outs=%b", c + 1, pack_outs(), InstrCount, ev[c]);
            end
        end
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_back_to_back();
        logic [14:0] ev [9];
        logic [8:0]  mr;
        logic [31:0] want;
        ev = '{V_FETCH_RDY, V_DECODE, V_EXECR, V_ALUWB, V_FETCH_RDY, V_DECODE, V_EXECI,
               V_ALUWB, V_FETCH_WAIT};
        mr = 9'b011111111;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            Op = (c < 4) ? OP_R : OP_I;
            MemReady = mr[c];
            #1;
            want = exp_cnt + ((c >= 4) ? 32'd1 : 32'd0) + ((c == 8) ? 32'd1 : 32'd0);
            total++;
            if (pack_outs() !== ev[c] || InstrCount !== want) begin
                bad++;
                $display("FAIL b2b_cyc%0d outs=%b cnt=%0d want outs=%b cnt=%0d", c + 1, pack_outs(), InstrCount, ev[c], want);
            end
        end
        exp_cnt = exp_cnt + 32'd2;
    endtask

    task automatic test_illegal();
        Op = OP_BAD;
        @(negedge clk); MemReady = 1'b1; #1;
        @(negedge clk); MemReady = 1'b1; #1;
        total++;
        if (pack_outs() !== V_DECODE) begin
            bad++;
            $display("FAIL ill_decode outs=%b want %b", pack_outs(), V_DECODE);
        end
`ifdef ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            MemReady = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (pack_outs() !== 15'd0 || Illegal !== 1'b1 || InstrCount !== exp_cnt) begin
                bad++;
                $display("FAIL trap_cyc%0d outs=%b ill=%b cnt=%0d want outs=0 ill=1 cnt=%0d", c, pack_outs(), Illegal, InstrCount, exp_cnt);
            end
        end
        @(negedge clk); rst = 1'b0; #1;
        total++;
        if (Illegal !== 1'b0 || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL trap_reset ill=%b cnt=%0d want 0 0", Illegal, InstrCount);
        end
        @(negedge clk); rst = 1'b1; MemReady = 1'b0; #1;
        exp_cnt = '0;
`else
        @(negedge clk); MemReady = 1'b0; #1;
        total++;
        if (pack_outs() !== V_FETCH_WAIT || InstrCount !== exp_cnt || Illegal !== 1'b0) begin
            bad++;
            $display("FAIL ill_nop outs=%b cnt=%0d ill=%b want outs=%b cnt=%0d ill=0", pack_outs(), InstrCount, Illegal, V_FETCH_WAIT, exp_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [1:0] rs_seen;
        int  wf, wm, ncyc, run, ridx;
        int  n_req, n_wr, n_rw, n_ir, n_imm, n_aop, cnt_bad;
        int  e_req, e_wr, e_rw, e_imm, e_aop;
        bit  is_mem, is_sw, is_lw, legal;
        for (int n = 0; n < 60; n++) begin
`ifdef ILLEGAL_TRAP_EN
            case ($urandom_range(0, 3))
`else
            case ($urandom_range(0, 4))
`endif
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_I;
                default: op = ($urandom_range(0, 1) == 0) ? OP_BAD : 7'b1100011;
            endcase
            wf = $urandom_range(0, 3);
            wm = $urandom_range(0, 3);
            is_lw  = (op == OP_LW);
            is_sw  = (op == OP_SW);
            is_mem = is_lw || is_sw;
            legal  = is_mem || op == OP_R || op == OP_I;
            ncyc   = (is_lw ? 5 : (legal ? 4 : 2)) + wf + (is_mem ? wm : 0);
            e_req  = wf + 1 + (is_mem ? wm + 1 : 0);
            e_wr   = is_sw ? wm + 1 : 0;
            e_rw   = (legal && !is_sw) ? 1 : 0;
            e_imm  = is_sw ? wm + 2 : 0;
            e_aop  = (op == OP_R || op == OP_I) ? 1 : 0;
            Op = op;
            run = 0; ridx = 0; rs_seen = 2'b11;
            n_req = 0; n_wr = 0; n_rw = 0; n_ir = 0; n_imm = 0; n_aop = 0; cnt_bad = 0;
            for (int c = 0; c < ncyc; c++) begin
                @(negedge clk);
                // Memory model: answer after the scheduled number of wait cycles.
                if (MemReq) MemReady = (run >= ((ridx == 0) ? wf : wm));
                else        MemReady = 1'($urandom_range(0, 1));
                #1;
                if (MemReq) begin
                    n_req++;
                    if (MemReady) begin ridx++; run = 0; end
                    else run++;
                end
                if (MemWrite) n_wr++;
                if (RegWrite) begin n_rw++; rs_seen = ResultSrc; end
                if (IRWrite) n_ir++;
                if (ImmSrc) n_imm++;
                if (ALUOp == 2'b10) n_aop++;
                if (InstrCount !== exp_cnt) cnt_bad++;
            end
            if (legal) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk);
            #1;
            total++;
            if (MemReq !== 1'b1 || AdrSrc !== 1'b0 || ALUSrcB !== 2'b10 || InstrCount !== exp_cnt || cnt_bad != 0) begin
                bad++;
                $display("FAIL rnd%0d_end op=%b req=%b as=%b cnt=%0d early=%0d want req=1 as=0 cnt=%0d", n, op, MemReq, AdrSrc, InstrCount, cnt_bad, exp_cnt);
            end
            total++;
            if (n_req != e_req || n_wr != e_wr || n_ir != 1) begin
                bad++;
                $display("FAIL rnd%0d_mem op=%b req=%0d wr=%0d ir=%0d want req=%0d wr=%0d ir=1", n, op, n_req, n_wr, n_ir, e_req, e_wr);
            end
            total++;
            if (n_rw != e_rw || n_imm != e_imm || n_aop != e_aop || (e_rw == 1 && rs_seen !== (is_lw ? 2'b01 : 2'b00))) begin
                bad++;
                $display("FAIL rnd%0d_ctl op=%b rw=%0d imm=%0d aop=%0d rs=%b want rw=%0d imm=%0d aop=%0d", n, op, n_rw, n_imm, n_aop, rs_seen, e_rw, e_imm, e_aop);
            end
        end
    endtask

    task automatic test_reset_mid();
        Op = OP_LW;
        @(negedge clk); MemReady = 1'b1; #1;
        @(negedge clk); MemReady = 1'b1; #1;
        @(negedge clk); MemReady = 1'b1; #1;
        @(negedge clk); MemReady = 1'b0; #1;
        total++;
        if (pack_outs() !== V_MEMREAD) begin
            bad++;
            $display("FAIL rstmid_memread outs=%b want %b", pack_outs(), V_MEMREAD);
        end
        @(negedge clk); rst = 1'b0; MemReady = 1'b1; #1;
        total++;
        if (pack_outs() !== 15'd0 || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_assert outs=%b cnt=%0d want 0 0", pack_outs(), InstrCount);
        end
        @(posedge clk); #1;
        total++;
        if (pack_outs() !== 15'd0 || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_hold outs=%b cnt=%0d want 0 0", pack_outs(), InstrCount);
        end
        @(negedge clk); rst = 1'b1; MemReady = 1'b0; #1;
        total++;
        if (pack_outs() !== V_FETCH_WAIT || InstrCount !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_release outs=%b cnt=%0d want %b 0", pack_outs(), InstrCount, V_FETCH_WAIT);
        end
        exp_cnt = '0;
    endtask

    task automatic test_wrap();
        logic [1:0] want;
        w_op = OP_R; w_mr = 1'b1;
        @(negedge clk); w_rst = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            want = 2'(((c - 1) / 4) % 4);
            total++;
            if (w_cnt !== want) begin
                bad++;
                $display("FAIL wrap_cyc%0d cnt=%0d want %0d", c, w_cnt, want);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; MemReady = 1'b0; Op = '0;
        w_rst = 1'b0; w_mr = 1'b0; w_op = '0;
        test_reset();
        test_lw_zero_wait();
        test_sw_wait();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the shared datapath (ALU, register file, immediate sign-extender, unified instruction/data memory) over multiple cycles per instruction, replacing the single-cycle main decoder. It drives the mux selects, write enables and the 1-bit `ImmSrc` select of the existing extender (0 = I-type, 1 = S-type). It handshakes with a variable-latency memory and counts retired instructions. Supported instructions: lw, sw, R-type ALU, I-type ALU.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `Op`  in  7  opcode from the instruction register (stable from DECODE onward)
- `MemReady`  in  1  memory completes the current request this cycle
- `MemReq`  out  1  memory request valid
- `MemWrite`  out  1  write strobe, qualified by `MemReq`
- `AdrSrc`  out  1  0 = PC, 1 = ALUOut
- `IRWrite`  out  1  load the instruction register
- `PCWrite`  out  1  load the PC
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- `ALUOp`  out  2  00 = add, 10 = funct decode
- `ImmSrc`  out  1  extender select
- `InstrCount`  out  CNT_W  retired-instruction count
- `Illegal`  out  1  sticky illegal-opcode flag (`ILLEGAL_TRAP_EN` only)

## Operation
Recognised opcodes: 0000011 = lw, 0100011 = sw, 0110011 = R, 0010011 = I. Outputs are a function of state, plus `MemReady` where noted. Any output not listed for a state is 0.

- **FETCH:** `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ResultSrc`=10. `IRWrite` = `PCWrite` = `MemReady`. Goes to DECODE on `MemReady`, otherwise holds.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01. Transitions:
  - lw or sw → MEMADR
  - R → EXECR
  - I → EXECI
  - any other opcode → FETCH (macro off) or TRAP (macro on)
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, `ImmSrc` = (Op == sw). Goes to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** `MemReq`=1, `AdrSrc`=1. Goes to MEMWB on `MemReady`.
- **MEMWB:** `RegWrite`=1, `ResultSrc`=01. Goes to FETCH and retires.
- **MEMWRITE:** `MemReq`=1, `MemWrite`=1, `AdrSrc`=1, `ImmSrc`=1. Goes to FETCH on `MemReady` and retires.
- **EXECR:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Goes to ALUWB.
- **EXECI:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10, `ImmSrc`=0. Goes to ALUWB.
- **ALUWB:** `RegWrite`=1, `ResultSrc`=00. Goes to FETCH and retires.

Retire rule: `InstrCount` increments by 1 on the clock edge that leaves MEMWB, leaves MEMWRITE, or leaves ALUWB. It wraps from 2^CNT_W−1 to 0.

## Timing
- State and `InstrCount` are registered.
- Outputs are combinational from state, plus `MemReady` in FETCH only.
- While `rst`=0: state = FETCH, `InstrCount` = 0, `Illegal` = 0, and every control output is forced to 0, including `MemReq`.
- The first `MemReq` appears in the first cycle after `rst` deasserts.
- Cycles per instruction with zero-wait memory: lw = 5, sw = 4, R = 4, I = 4. Each wait cycle (`MemReady`=0 in FETCH, MEMREAD or MEMWRITE) adds 1 cycle.
- Memory handshake:
  - `MemReq`, `MemWrite` and `AdrSrc` stay constant while waiting.
  - A request completes in exactly the cycle `MemReady`=1.
  - `MemReady` outside a requesting state is ignored.
- Reset asserted mid-instruction aborts immediately. No partial retire and no write enables during or after the abort.
- `MemReady`=1 in the same cycle as reset assertion is ignored.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An unrecognised opcode in DECODE goes to TRAP. All control outputs are 0 there and `Illegal`=1.
  - TRAP is held until reset. `InstrCount` freezes.
- `ILLEGAL_TRAP_EN` undefined:
  - An unrecognised opcode returns to FETCH as a NOP and is not counted.
  - The TRAP state does not exist and `Illegal` is tied to 0.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum
  - opcode constants
  - `ResultSrc`, `ALUSrcA` and `ALUSrcB` encodings
  - `ALUOp` encodings
- One sub-module, `ctrl_out_dec`: a purely combinational state + `Op` + `MemReady` → control-output decoder.
- The top level holds the state register, next-state logic, counter and reset gating.

## Test plan
- **Zero-wait lw** (`Op`=0000011, `MemReady`=1): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `RegWrite`=1 with `ResultSrc`=01 in cycle 5. `InstrCount` 0 → 1.
- **sw with 3 wait cycles in MEMWRITE:** `MemReq`=`MemWrite`=1 and `ImmSrc`=1 held for 4 cycles. Total 7 cycles; `InstrCount` +1.
- **R then I back-to-back, zero-wait:** 8 cycles total. `ALUSrcB`=00 in EXECR and 01 in EXECI. `InstrCount` = 2.
- **Opcode 1111111:**
  - macro on: TRAP and `Illegal`=1 held 10 cycles; `MemReq`=0.
  - macro off: next cycle is FETCH; `InstrCount` unchanged.
- **Reset pulse during MEMREAD:** all outputs 0 immediately; after release, FETCH with `MemReq`=1 and `InstrCount`=0.
- **Preload near wrap:** force `InstrCount` to 2^CNT_W−1, retire one ALU instruction → `InstrCount` = 0.
